namuru_dump_ctrl: RTL and testbench

Sits in the sys_clk domain between the CPU Wishbone slave port and the GPS correlator's Wishbone port. On each accumulation interrupt it automatically reads every enabled channel's six accumulators (IE, QE, IP, QP, IL, QL) and streams them out to a capture buffer. When the dump engine is idle, it passes CPU accesses through to the correlator. Arbitration is done at Wishbone-cycle granularity.

---
 rtl/namuru_dump_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_namuru_dump_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/namuru_dump_ctrl.sv
// namuru_dump_ctrl: sits between the CPU Wishbone slave port and the correlator master port and dumps accumulators on each accum_int.
// Build macro NAMURU_DUMP_TIMEOUT_EN adds a master-ack timeout that sets dump_err and aborts the dump.
module namuru_dump_ctrl #(
    parameter int          NUM_CHAN    = 4,
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter logic [31:0] CHAN_STRIDE = 32'h0000_0040,
    parameter logic [31:0] REG_OFFSET  = 32'h0000_0010
`ifdef NAMURU_DUMP_TIMEOUT_EN
    ,
    parameter int          TIMEOUT     = 255
`endif
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                accum_int,
    input  logic                dump_en,
    input  logic [NUM_CHAN-1:0] ch_mask,
    input  logic [31:0]         s_adr_i,
    input  logic [31:0]         s_dat_i,
    input  logic [3:0]          s_sel_i,
    input  logic                s_we_i,
    input  logic                s_stb_i,
    input  logic                s_cyc_i,
    output logic [31:0]         s_dat_o,
    output logic                s_ack_o,
    output logic [31:0]         m_adr_o,
    output logic [31:0]         m_dat_o,
    output logic [3:0]          m_sel_o,
    output logic                m_we_o,
    output logic                m_stb_o,
    output logic                m_cyc_o,
    input  logic [31:0]         m_dat_i,
    input  logic                m_ack_i,
    output logic                dump_valid,
    output logic [31:0]         dump_dat,
    output logic [3:0]          dump_ch,
    output logic [2:0]          dump_reg,
    output logic                dump_done,
    output logic                dump_err,
    output logic                busy,
    output logic                overrun
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PASS = 3'd1,
        ST_LOAD = 3'd2,
        ST_REQ  = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q, prev_q;
    logic                  pend_q, pend_d;
    logic                  overrun_q, overrun_d;
    logic [NUM_CHAN-1:0]   mask_q, mask_d;
    logic [3:0]            ch_q, ch_d;
    logic [2:0]            reg_q, reg_d;
    logic                  busy_q;
    logic                  dump_valid_q, dump_done_q;
    logic [31:0]           dump_dat_q;
    logic [3:0]            dump_ch_q;
    logic [2:0]            dump_reg_q;

    logic                  rise_s, active_s, set_pend_s, pass_s, cap_s, tmo_hit_s;
    logic [4:0]            first_s, next_s;
    logic [31:0]           eng_adr_s;

    // Returns {found, index} of the lowest set mask bit at or above start.
    function automatic logic [4:0] find_set(input logic [NUM_CHAN-1:0] mask, input logic [4:0] start);
        logic [4:0] res;
        res = 5'd0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= start)) begin
                res = {1'b1, 4'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign rise_s     = sync2_q & ~prev_q;
    assign active_s   = (state_q == ST_LOAD) || (state_q == ST_REQ) ||
                        (state_q == ST_NEXT) || (state_q == ST_DONE);
    assign set_pend_s = rise_s & dump_en & (|ch_mask) & ~active_s;
    assign pass_s     = (state_q == ST_IDLE) || (state_q == ST_PASS);
    assign first_s    = find_set(ch_mask, 5'd0);
    assign next_s     = find_set(mask_q, {1'b0, ch_q} + 5'd1);
    assign eng_adr_s  = BASE_ADR + ({28'd0, ch_q} * CHAN_STRIDE) + REG_OFFSET + {27'd0, reg_q, 2'b00};

    // Next-state and dump bookkeeping for the dump engine.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ch_d      = ch_q;
        reg_d     = reg_q;
        cap_s     = 1'b0;
        overrun_d = overrun_q | (rise_s & active_s);
        if (set_pend_s) begin
            pend_d = 1'b1;
        end else if ((state_q == ST_IDLE) && !dump_en) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        case (state_q)
            ST_IDLE: begin
                // CPU takes priority over a pending dump.
                if (s_cyc_i) begin
                    state_d = ST_PASS;
                end else if ((pend_q & dump_en) | set_pend_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (!s_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PASS;
                end
            end
            ST_LOAD: begin
                pend_d = 1'b0;
                mask_d = ch_mask;
                ch_d   = first_s[3:0];
                reg_d  = 3'd0;
                if (first_s[4]) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_REQ: begin
                if (m_ack_i) begin
                    cap_s   = 1'b1;
                    state_d = ST_NEXT;
                end else if (tmo_hit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_NEXT: begin
                if (reg_q < 3'd5) begin
                    reg_d   = reg_q + 3'd1;
                    state_d = ST_REQ;
                end else if (next_s[4]) begin
                    ch_d    = next_s[3:0];
                    reg_d   = 3'd0;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, synchronizer and engine registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
            mask_q    <= '0;
            ch_q      <= 4'd0;
            reg_q     <= 3'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= accum_int;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            mask_q    <= mask_d;
            ch_q      <= ch_d;
            reg_q     <= reg_d;
            busy_q    <= (state_q == ST_LOAD) || (state_q == ST_REQ) || (state_q == ST_NEXT);
        end
    end

    // Capture register feeding the dump stream.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            dump_dat_q   <= 32'd0;
            dump_ch_q    <= 4'd0;
            dump_reg_q   <= 3'd0;
        end else begin
            dump_valid_q <= cap_s;
            dump_done_q  <= (state_q == ST_DONE);
            if (cap_s) begin
                dump_dat_q <= m_dat_i;
                dump_ch_q  <= ch_q;
                dump_reg_q <= reg_q;
            end else begin
                dump_dat_q <= dump_dat_q;
                dump_ch_q  <= dump_ch_q;
                dump_reg_q <= dump_reg_q;
            end
        end
    end

`ifdef NAMURU_DUMP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          dump_err_q;

    assign tmo_hit_s = (state_q == ST_REQ) && (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign dump_err  = dump_err_q;

    // Ack timeout counter restarts on every REQ entry; error is sticky until the next LOAD.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmo_cnt_q  <= '0;
            dump_err_q <= 1'b0;
        end else begin
            if ((state_q == ST_REQ) && (state_d == ST_REQ)) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_q <= '0;
            end
            if (state_q == ST_LOAD) begin
                dump_err_q <= 1'b0;
            end else if (tmo_hit_s && !m_ack_i) begin
                dump_err_q <= 1'b1;
            end else begin
                dump_err_q <= dump_err_q;
            end
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign dump_err  = 1'b0;
`endif

    // Bus ownership: CPU passes straight through while idle, otherwise the engine drives the master port.
    always_comb begin
        m_adr_o = 32'd0;
        m_dat_o = 32'd0;
        m_sel_o = 4'h0;
        m_we_o  = 1'b0;
        m_stb_o = 1'b0;
        m_cyc_o = 1'b0;
        s_dat_o = 32'd0;
        s_ack_o = 1'b0;
        if (pass_s) begin
            m_adr_o = s_adr_i;
            m_dat_o = s_dat_i;
            m_sel_o = s_sel_i;
            m_we_o  = s_we_i;
            m_stb_o = s_stb_i;
            m_cyc_o = s_cyc_i;
            s_dat_o = m_dat_i;
            s_ack_o = m_ack_i;
        end else if (state_q == ST_REQ) begin
            m_adr_o = eng_adr_s;
            m_sel_o = 4'hF;
            m_stb_o = 1'b1;
            m_cyc_o = 1'b1;
        end else begin
            m_cyc_o = 1'b0;
        end
    end

    assign dump_valid = dump_valid_q;
    assign dump_dat   = dump_dat_q;
    assign dump_ch    = dump_ch_q;
    assign dump_reg   = dump_reg_q;
    assign dump_done  = dump_done_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_namuru_dump_ctrl.sv
// Scoreboard bench for namuru_dump_ctrl: a correlator slave model returns address^salt, expected dump words are queued per interrupt.
module tb_namuru_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        accum_int, dump_en;
    logic [3:0]  ch_mask;
    logic [31:0] s_adr_i, s_dat_i, s_dat_o, m_adr_o, m_dat_o, m_dat_i, dump_dat;
    logic [3:0]  s_sel_i, m_sel_o, dump_ch;
    logic        s_we_i, s_stb_i, s_cyc_i, s_ack_o, m_we_o, m_stb_o, m_cyc_o, m_ack_i;
    logic [2:0]  dump_reg;
    logic        dump_valid, dump_done, dump_err, busy, overrun;

    typedef struct {
        logic [3:0]  ch;
        logic [2:0]  rg;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_vec = 0, n_err = 0;
    int          exp_done = 0, act_done = 0, mcyc_cnt = 0;
    int          cnt = 0;
    bit          hold = 1'b0, noack = 1'b0;
    logic [31:0] salt;

    namuru_dump_ctrl #(
        .NUM_CHAN(4)
`ifdef NAMURU_DUMP_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .accum_int(accum_int), .dump_en(dump_en), .ch_mask(ch_mask),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_sel_i(s_sel_i), .s_we_i(s_we_i),
        .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_we_o(m_we_o),
        .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
        .dump_valid(dump_valid), .dump_dat(dump_dat), .dump_ch(dump_ch), .dump_reg(dump_reg),
        .dump_done(dump_done), .dump_err(dump_err), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: one word per enabled channel and register, at base 0 + ch*0x40 + 0x10 + reg*4.
    task automatic push_dump(input logic [3:0] mask);
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            if (mask[c]) begin
                for (int r = 0; r < 6; r++) begin
                    e.ch  = 4'(c);
                    e.rg  = 3'(r);
                    e.dat = (32'h10 + 32'(c) * 32'h40 + 32'(r) * 32'd4) ^ salt;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic fire(input bit expect_dump);
        @(negedge clk);
        accum_int = 1'b0;
        repeat (3) @(negedge clk);
        accum_int = 1'b1;
        if (expect_dump) begin
            push_dump(ch_mask);
            exp_done++;
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (act_done != exp_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(act_done), 32'(exp_done));
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_busy();
        int t;
        t = 0;
        while (!busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output bit ok,
                            output logic [31:0] adr_seen, output bit ack_co);
        @(negedge clk);
        s_adr_i = a; s_sel_i = 4'hF; s_we_i = 1'b0; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        ok = 1'b0; d = 32'd0; adr_seen = 32'd0; ack_co = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(posedge clk);
            #1;
            if (s_ack_o) begin
                ok = 1'b1; d = s_dat_o; adr_seen = m_adr_o; ack_co = m_ack_i;
            end
        end
        @(negedge clk);
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
    endtask

    // Correlator slave: single-cycle ack after 1..3 cycles, data derived from the address.
    always @(negedge clk) begin
        if (m_ack_i) begin
            m_ack_i = 1'b0;
        end else if (m_cyc_o && m_stb_o && !hold && !noack) begin
            if (cnt == 0) begin
                m_ack_i = 1'b1;
                m_dat_i = m_adr_o ^ salt;
                hold    = 1'b1;
                cnt     = $urandom_range(0, 2);
            end else begin
                cnt--;
            end
        end
        if (!(m_cyc_o && m_stb_o)) hold = 1'b0;
    end

    // Monitor: pops the scoreboard on every dump_valid and tallies dump_done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_cyc_o && !s_cyc_i) mcyc_cnt++;
            if (m_ack_i && busy) begin
                check("m_we", 32'(m_we_o), 32'd0);
                check("m_sel", 32'(m_sel_o), 32'hF);
            end
            if (dump_valid) begin
                check("busy_dv", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dump_valid: got unexpected word ch=%0d reg=%0d required none", dump_ch, dump_reg);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dump_ch", 32'(dump_ch), 32'(mon_e.ch));
                    check("dump_reg", 32'(dump_reg), 32'(mon_e.rg));
                    check("dump_dat", dump_dat, mon_e.dat);
                end
            end
            if (dump_done) begin
                act_done++;
                check("busy_at_done", 32'(busy), 32'd0);
                check("words_left", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] d, adr;
        bit          ok, co;
        int          lat, c0;
        salt = $urandom;
        rst = 1'b1; accum_int = 1'b0; dump_en = 1'b0; ch_mask = 4'd0;
        s_adr_i = 32'd0; s_dat_i = 32'd0; s_sel_i = 4'd0; s_we_i = 1'b0; s_stb_i = 1'b0; s_cyc_i = 1'b0;
        m_dat_i = 32'd0; m_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_err", 32'(dump_err), 32'd0);
        check("rst_mcyc", 32'(m_cyc_o), 32'd0);
        check("rst_sack", 32'(s_ack_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed dump of channels 0 and 2 with edge-to-strobe latency.
        dump_en = 1'b1; ch_mask = 4'b0101;
        fire(1'b1);
        lat = 0;
        while (!m_stb_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        wait_done("dump_0101");

        // CPU pass-through read while idle.
        cpu_read(32'h34, d, ok, adr, co);
        check("pass_ack", 32'(ok), 32'd1);
        check("pass_adr", adr, 32'h34);
        check("pass_dat", d, 32'h34 ^ salt);
        check("pass_ack_co", 32'(co), 32'd1);

        // Randomized channel masks.
        for (int k = 0; k < 6; k++) begin
            ch_mask = 4'($urandom_range(1, 15));
            fire(1'b1);
            wait_done("dump_rand");
        end

        // Interrupt while the CPU holds a cycle: dump waits for s_cyc_i to fall.
        @(negedge clk);
        s_adr_i = 32'h0; s_cyc_i = 1'b1; s_stb_i = 1'b0;
        ch_mask = 4'b1000;
        fire(1'b1);
        repeat (12) @(negedge clk);
        check("hold_busy", 32'(busy), 32'd0);
        check("hold_words", 32'(exp_q.size()), 32'd6);
        s_cyc_i = 1'b0;
        wait_done("dump_after_cpu");

        // CPU cycle during a dump stalls until the dump finishes.
        ch_mask = 4'b0011;
        fire(1'b1);
        wait_busy();
        cpu_read(32'h48, d, ok, adr, co);
        check("stall_ack", 32'(ok), 32'd1);
        check("stall_after_done", 32'(act_done), 32'(exp_done));
        check("stall_dat", d, 32'h48 ^ salt);
        wait_done("dump_stall");

        // Second edge mid-dump sets sticky overrun and is dropped.
        ch_mask = 4'b1111;
        fire(1'b1);
        wait_busy();
        fire(1'b0);
        wait_done("dump_overrun");
        check("overrun_set", 32'(overrun), 32'd1);
        ch_mask = 4'b0001;
        fire(1'b1);
        wait_done("dump_post_overrun");
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Disabled or empty mask: no master cycles, no dump_done.
        dump_en = 1'b0; ch_mask = 4'b0110;
        c0 = mcyc_cnt;
        fire(1'b0);
        repeat (10) @(negedge clk);
        dump_en = 1'b1;
        repeat (10) @(negedge clk);
        check("dis_mcyc", 32'(mcyc_cnt), 32'(c0));
        ch_mask = 4'b0000;
        fire(1'b0);
        repeat (15) @(negedge clk);
        check("mask0_mcyc", 32'(mcyc_cnt), 32'(c0));
        check("mask0_done", 32'(act_done), 32'(exp_done));

`ifdef NAMURU_DUMP_TIMEOUT_EN
        // Timeout: no ack, engine gives up after 8 cycles and flags dump_err.
        ch_mask = 4'b0010; noack = 1'b1;
        c0 = mcyc_cnt;
        fire(1'b0);
        exp_done++;
        wait_done("tmo_done");
        check("tmo_len", 32'(mcyc_cnt - c0), 32'd8);
        check("tmo_err", 32'(dump_err), 32'd1);
        noack = 1'b0; cnt = 0;
        fire(1'b1);
        wait_busy();
        check("tmo_err_clr", 32'(dump_err), 32'd0);
        wait_done("tmo_recover");
`else
        check("err_tied", 32'(dump_err), 32'd0);
`endif

        // Reset mid-dump releases the bus and clears overrun.
        ch_mask = 4'b1111;
        fire(1'b1);
        wait_busy();
        repeat (10) @(negedge clk);
        rst = 1'b1; accum_int = 1'b0;
        #1;
        check("rst_mid_mcyc", 32'(m_cyc_o), 32'd0);
        check("rst_mid_overrun", 32'(overrun), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        exp_q.delete();
        exp_done = act_done;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_no_done", 32'(act_done), 32'(exp_done));
        ch_mask = 4'b0100;
        fire(1'b1);
        wait_done("dump_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
